// File: rtl/shift_seq_pkg.sv
// rtl/shift_seq_pkg.sv - shared state encoding, default width and count clamp for the shift sequencer
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 4;

    function automatic int clamp_count(input int count, input int width);
        return (count > width) ? width : count;
    endfunction

endpackage

// File: rtl/shift_seq_queue.sv
// rtl/shift_seq_queue.sv - one-entry valid/ready holding buffer
module shift_seq_queue #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_tvalid,
    output logic          s_tready,
    input  logic [DW-1:0] s_tdata,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic [DW-1:0] m_tdata
);

    logic full_q;
    logic ready_q;
    logic push;
    logic pop;
    logic full_d;

    assign push     = s_tvalid && ready_q;
    assign pop      = m_tready && full_q;
    assign full_d   = push || (full_q && !pop);
    assign s_tready = ready_q;
    assign m_tvalid = full_q;

    // ready is registered so it stays low through reset and rises one edge later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q  <= 1'b0;
            ready_q <= 1'b0;
            m_tdata <= '0;
        end else begin
            full_q  <= full_d;
            ready_q <= !full_d;
            if (push) begin
                m_tdata <= s_tdata;
            end
        end
    end

endmodule

// File: rtl/shift_load_sequencer.sv
// rtl/shift_load_sequencer.sv - load/shift sequencer for left_shift_register; SHIFT_SEQ_QUEUE_EN adds a one-entry input buffer
module shift_load_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] in_count,
    output logic             load,
    output logic [WIDTH-1:0] d,
    output logic             shift_en,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] exp_q
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] expv_q, expv_d;

    logic             take_new;
    logic [WIDTH-1:0] new_data;
    logic [CNT_W-1:0] new_count;
    logic [CNT_W-1:0] new_count_clamped;

`ifdef SHIFT_SEQ_QUEUE_EN
    logic             q_valid;
    logic             q_ready;
    logic             q_pop;
    logic             direct;
    logic [CNT_W+WIDTH-1:0] q_data;

    // A word offered when the FSM can start it right away bypasses the buffer
    assign direct   = (state_q == IDLE) || ((state_q == DONE) && !q_valid);
    assign q_pop    = (state_q == DONE) && q_valid;
    assign in_ready = q_ready;
    assign take_new = (in_valid && in_ready && direct) || q_pop;
    assign {new_count, new_data} = q_pop ? q_data : {in_count, in_data};

    shift_seq_queue #(
        .DW(CNT_W + WIDTH)
    ) u_queue (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tvalid (in_valid && !direct),
        .s_tready (q_ready),
        .s_tdata  ({in_count, in_data}),
        .m_tvalid (q_valid),
        .m_tready (q_pop),
        .m_tdata  (q_data)
    );
`else
    logic ready_q;

    assign in_ready  = ready_q;
    assign take_new  = in_valid && in_ready;
    assign new_data  = in_data;
    assign new_count = in_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= (state_d == IDLE);
        end
    end
`endif

    assign new_count_clamped = CNT_W'(clamp_count(int'(new_count), WIDTH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            word_q  <= '0;
            cnt_q   <= '0;
            expv_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            expv_q  <= expv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        expv_d  = expv_q;
        case (state_q)
            IDLE:    if (take_new) state_d = LOAD;
            LOAD:    state_d = (cnt_q != '0) ? SHIFT : DONE;
            SHIFT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = DONE;
            end
            DONE:    state_d = take_new ? LOAD : IDLE;
            default: state_d = IDLE;
        endcase
        if (take_new) begin
            word_d = new_data;
            cnt_d  = new_count_clamped;
            expv_d = new_data << new_count_clamped;
        end
    end

    // Outputs are registered copies of what the next state implies
    logic             load_nxt;
    logic [WIDTH-1:0] d_nxt;
    logic             shift_en_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic [WIDTH-1:0] exp_nxt;

    always_comb begin
        load_nxt     = (state_d == LOAD);
        d_nxt        = (state_d == LOAD) ? word_d : d;
        shift_en_nxt = (state_d == SHIFT);
        busy_nxt     = (state_d != IDLE);
        done_nxt     = (state_d == DONE);
        exp_nxt      = (state_d == DONE) ? expv_d : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load     <= 1'b0;
            d        <= '0;
            shift_en <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            exp_q    <= '0;
        end else begin
            load     <= load_nxt;
            d        <= d_nxt;
            shift_en <= shift_en_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            exp_q    <= exp_nxt;
        end
    end

endmodule

// File: tb/tb_shift_load_sequencer.sv
// tb/tb_shift_load_sequencer.sv - self-checking bench for shift_load_sequencer
module tb_shift_load_sequencer;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic [CNT_W-1:0] in_count = '0;
    logic             load;
    logic [WIDTH-1:0] d;
    logic             shift_en;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] exp_q;

    int n_checks = 0;
    int n_fail   = 0;

    shift_load_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_count (in_count),
        .load     (load),
        .d        (d),
        .shift_en (shift_en),
        .busy     (busy),
        .done     (done),
        .exp_q    (exp_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    function automatic int model_count(input int cnt);
        return (cnt > WIDTH) ? WIDTH : cnt;
    endfunction

    function automatic int model_exp(input int data, input int cnt);
        return (data * (1 << model_count(cnt))) % (1 << WIDTH);
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, in_ready, 0);
        chk({tag, "_load"}, load, 0);
        chk({tag, "_d"}, d, 0);
        chk({tag, "_shift"}, shift_en, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_exp"}, exp_q, 0);
    endtask

    // Offer one word, then walk the expected cycle timeline after the accept edge
    task automatic run_word(input string tag, input int data, input int cnt);
        int guard;
        int c;
        c = model_count(cnt);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = WIDTH'(data);
        in_count = CNT_W'(cnt);
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_ready_wait"}, guard < 20, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = WIDTH'($urandom);
        in_count = CNT_W'($urandom);
        for (int k = 1; k <= c + 2; k++) begin
            chk($sformatf("%s_load_k%0d", tag, k), load, (k == 1));
            chk($sformatf("%s_shift_k%0d", tag, k), shift_en, (k >= 2 && k <= c + 1));
            chk($sformatf("%s_done_k%0d", tag, k), done, (k == c + 2));
            chk($sformatf("%s_busy_k%0d", tag, k), busy, 1);
            if (k == 1) chk({tag, "_d"}, d, data);
            if (k == c + 2) chk({tag, "_exp"}, exp_q, model_exp(data, cnt));
`ifndef SHIFT_SEQ_QUEUE_EN
            chk($sformatf("%s_ready_k%0d", tag, k), in_ready, 0);
`endif
            @(negedge clk);
        end
        chk({tag, "_after_done"}, done, 0);
        chk({tag, "_after_busy"}, busy, 0);
        chk({tag, "_after_ready"}, in_ready, 1);
        chk({tag, "_d_hold"}, d, data);
    endtask

    initial begin
        int data;
        int cnt;

        #2;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        chk("ready_before_edge", in_ready, 0);
        @(negedge clk);
        chk("ready_after_edge", in_ready, 1);

        run_word("full", 4'b1101, 4);
        run_word("partial", 4'b1101, 2);
        run_word("loadonly", 4'b1011, 0);
        run_word("clamp", 4'b0001, 7);

        // Reset during the second SHIFT cycle
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 4'b1101;
        in_count = 3'd4;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("rst_mid_pre_shift", shift_en, 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("rst_mid_nodone_%0d", k), done, 0);
        end
        rst_n = 1'b1;
        chk("rst_mid_ready_low", in_ready, 0);
        @(negedge clk);
        chk("rst_mid_ready_high", in_ready, 1);
        chk("rst_mid_idle", busy, 0);
        run_word("post_rst", 4'b0110, 1);

        for (int i = 0; i < 20; i++) begin
            data = int'($urandom_range(0, 15));
            cnt  = int'($urandom_range(0, 7));
            run_word($sformatf("rand%0d", i), data, cnt);
        end

`ifdef SHIFT_SEQ_QUEUE_EN
        // Back-to-back: second word buffered while the first is in flight
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 4'b1101;
        in_count = 3'd2;
        @(posedge clk);
        @(negedge clk);
        in_data  = 4'b0110;
        in_count = 3'd1;
        chk("b2b_load1", load, 1);
        chk("b2b_ready_busy", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b_shift1a", shift_en, 1);
        chk("b2b_ready_full", in_ready, 0);
        @(negedge clk);
        chk("b2b_shift1b", shift_en, 1);
        @(negedge clk);
        chk("b2b_done1", done, 1);
        chk("b2b_exp1", exp_q, 4'b0100);
        @(negedge clk);
        chk("b2b_load2", load, 1);
        chk("b2b_d2", d, 4'b0110);
        chk("b2b_nodone", done, 0);
        @(negedge clk);
        chk("b2b_shift2", shift_en, 1);
        @(negedge clk);
        chk("b2b_done2", done, 1);
        chk("b2b_exp2", exp_q, 4'b1100);
        @(negedge clk);
        chk("b2b_idle", busy, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
